// File: rtl/mux_rr.sv
// mux_rr: N-way registered selector with valid/ready handshakes.
// Grant policy: external select, fixed priority or round-robin.
module mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_idx
);

  logic             load;
  logic             any;
  logic [SW-1:0]    gidx;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    ptr_nxt;
  logic [N-1:0]     gnt;
  logic [WIDTH-1:0] dsel;

  // Reset forces load so in_ready mirrors the grant while rst is high.
  assign load = rst || !out_valid || out_ready;

  always_comb begin : pick
    int d;
    int best;
    any  = 1'b0;
    gidx = '0;
    best = N;
    d    = 0;
    unique case (MODE)
      0: begin
        for (int i = 0; i < N; i++) begin
          if (sel == SW'(i) && in_valid[i]) begin
            any  = 1'b1;
            gidx = SW'(i);
          end
        end
      end
      1: begin
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            any  = 1'b1;
            gidx = SW'(i);
          end
        end
      end
      default: begin
        // Nearest valid channel at or above ptr, modulo N.
        for (int i = 0; i < N; i++) begin
          d = (i + N - int'(ptr)) % N;
          if (in_valid[i] && d < best) begin
            best = d;
            any  = 1'b1;
            gidx = SW'(i);
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt  = '0;
    dsel = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (gidx == SW'(i));
      if (gnt[i]) dsel = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = gnt & {N{load}};

  assign ptr_nxt = (gidx == SW'(N - 1))
                 ? '0 : gidx + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= dsel;
        out_idx  <= gidx;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: four mux_rr variants on shared stimulus, checked
// every cycle against a behavioural model plus literal pins.
module tb_mux_rr;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [1:0]     sel;
  logic           out_ready;

  logic [3:0]   rdy [4];
  logic [2:0]   rdy3;
  logic         vld [4];
  logic [1:0]   idx [4];
  logic [W-1:0] dat [4];

  assign rdy[3] = {1'b0, rdy3};

  mux_rr #(.WIDTH(W), .N(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[0]), .sel(sel),
    .out_data(dat[0]), .out_valid(vld[0]),
    .out_ready(out_ready), .out_idx(idx[0]));

  mux_rr #(.WIDTH(W), .N(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[1]), .sel(sel),
    .out_data(dat[1]), .out_valid(vld[1]),
    .out_ready(out_ready), .out_idx(idx[1]));

  mux_rr #(.WIDTH(W), .N(4), .MODE(2)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[2]), .sel(sel),
    .out_data(dat[2]), .out_valid(vld[2]),
    .out_ready(out_ready), .out_idx(idx[2]));

  mux_rr #(.WIDTH(W), .N(3), .MODE(2)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]),
    .in_valid(in_valid[2:0]), .in_ready(rdy3), .sel(sel),
    .out_data(dat[3]), .out_valid(vld[3]),
    .out_ready(out_ready), .out_idx(idx[3]));

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  int md [4] = '{0, 1, 2, 2};
  int nn [4] = '{4, 4, 4, 3};

  bit           mv   [4];
  logic [W-1:0] mdat [4];
  int           midx [4];
  int           mptr [4];
  int           acc  [4][4];
  int           dlv  [4][4];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Granted channel from the policy rules, -1 when none.
  function automatic int grant(input int mode, input int n,
                               input logic [3:0] v,
                               input logic [1:0] s,
                               input int p);
    int i;
    if (mode == 0)
      return (int'(s) < n && v[s]) ? int'(s) : -1;
    for (int k = 0; k < n; k++) begin
      i = (mode == 2) ? (p + k) % n : k;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin : model
      int g;
      bit ld;
      g  = grant(md[j], nn[j], in_valid, sel, mptr[j]);
      ld = rst || !mv[j] || out_ready;
      if (rst) begin
        mv[j]   = 1'b0;
        mdat[j] = '0;
        midx[j] = 0;
        mptr[j] = 0;
      end else if (ld) begin
        if (g >= 0) begin
          mv[j]   = 1'b1;
          mdat[j] = W'(in_data >> (g * W));
          midx[j] = g;
          mptr[j] = (g + 1) % nn[j];
        end else begin
          mv[j] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          acc[j][c] = 0;
          dlv[j][c] = 0;
        end else if (in_valid[c] && rdy[j][c]) begin
          acc[j][c]++;
        end
      end
      if (!rst && vld[j] && out_ready)
        dlv[j][idx[j]]++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int j = 0; j < 4; j++) begin : cmp
        int g;
        bit ld;
        logic [3:0] er;
        g  = grant(md[j], nn[j], in_valid, sel, mptr[j]);
        ld = rst || !mv[j] || out_ready;
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
        chk($sformatf("ready%0d", j), 32'(rdy[j]), 32'(er));
        chk($sformatf("valid%0d", j), 32'(vld[j]), 32'(mv[j]));
        chk($sformatf("idx%0d", j), 32'(idx[j]), 32'(midx[j]));
        chk($sformatf("data%0d", j), dat[j], mdat[j]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    sel       = 2'd0;
    for (int i = 0; i < 4; i++)
      in_data[i*W +: W] = 32'hA000_0000 + 32'(i);

    cyc();
    armed = 1'b1;
    cyc();
    chk("rst_valid", 32'(vld[2]), 32'd0);
    chk("rst_data", dat[2], 32'd0);
    chk("rst_idx", 32'(idx[2]), 32'd0);
    chk("rst_ready", 32'(rdy[2]), 32'h1);

    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr4_seq", 32'(idx[2]), 32'(k % 4));
      chk("rr3_seq", 32'(idx[3]), 32'(k % 3));
    end
    chk("rr4_data", dat[2], 32'hA000_0003);

    cyc();
    cyc();
    chk("pre_rst_idx", 32'(idx[2]), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", 32'(vld[2]), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_idx", 32'(idx[2]), 32'd0);
    chk("post_rst_valid", 32'(vld[2]), 32'd1);

    sel = 2'd2;
    in_data[2*W +: W] = 32'hDEADBEEF;
    #1;
    chk("sel_ready", 32'(rdy[0]), 32'h4);
    cyc();
    chk("sel_data", dat[0], 32'hDEADBEEF);
    chk("sel_idx", 32'(idx[0]), 32'd2);
    in_valid = 4'b1011;
    cyc();
    chk("sel_drain", 32'(vld[0]), 32'd0);

    in_valid = 4'b1010;
    repeat (3) begin
      cyc();
      chk("prio_idx", 32'(idx[1]), 32'd1);
    end
    in_valid = 4'b1000;
    cyc();
    chk("prio_next", 32'(idx[1]), 32'd3);

    in_valid = 4'hF;
    cyc();
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_ready", 32'(rdy[2]), 32'd0);
      chk("bp_valid", 32'(vld[2]), 32'd1);
    end
    out_ready = 1'b1;

    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++)
        in_data[i*W +: W] = $urandom;
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      cyc();
    end

    rst       = 1'b0;
    in_valid  = 4'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("sb%0d_ch%0d", j, c),
            32'(dlv[j][c]), 32'(acc[j][c]));

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised N-way registered data selector with valid/ready handshakes on every input and on the output. It generalises the datapath multiplexers to arbitrary width and channel count. It adds three selection modes: external select, fixed priority and round-robin. It sits wherever several producers share one consumer, for example write-back sources or memory requesters in the multicycle and pipelined datapaths.

## Interface
- `WIDTH`, 32: data width per channel, ≥1.
- `N`, 4: number of input channels, 2..16.
- `MODE`, 2: selection policy.
  - 0: external select via `sel`.
  - 1: fixed priority, lowest index wins.
  - 2: round-robin.
- `SW`, $clog2(N): width of the select and index fields (derived; do not override).

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input N: channel i presents a beat.
- `in_ready` output N: channel i beat accepted this cycle when valid and ready are both high.
- `sel` input SW: channel index; used only in MODE 0.
- `out_data` output WIDTH: registered selected data.
- `out_valid` output 1: `out_data` holds a beat.
- `out_ready` input 1: consumer accepts the beat.
- `out_idx` output SW: source channel of the beat currently in `out_data`.

## Operation
- A single output register stage holds at most one beat.
- `load = !out_valid || out_ready`. The stage may accept a new beat only when `load` is high.
- Grant vector `gnt[N]` is combinational and one-hot or zero. It is a function of `in_valid`, the mode, and the pointer or `sel`.
  - MODE 0: `gnt[sel] = in_valid[sel]`. If `sel ≥ N`, there is no grant.
  - MODE 1: grant the lowest i with `in_valid[i]`.
  - MODE 2: grant the first valid i scanning from `ptr` upward, wrapping N-1 → 0.
- `in_ready = gnt & {N{load}}`. `in_ready` must never depend on `in_valid` of a non-granted channel in a way that creates a loop with the producer. Producers must not make `in_valid` depend on `in_ready`.
- On accept (`load` and `|gnt`), the stage updates on the same edge:
  - `out_data` ← data of the granted channel
  - `out_idx` ← granted index
  - `out_valid` ← 1
- When `load` is high with no grant, `out_valid` ← 0 (the stage drains). `out_data` and `out_idx` hold their values.
- When `out_valid && !out_ready`, all output registers hold and `in_ready` is all-zero. This is backpressure.
- Round-robin pointer `ptr` (SW bits, internal):
  - On each accept, `ptr` ← granted index + 1, with N-1 wrapping to 0.
  - `ptr` is unchanged otherwise.
  - `ptr` is unused in MODE 0 and MODE 1.
- Round-robin fairness: with all N channels continuously valid and `out_ready` held high, each channel is granted exactly once per N consecutive accepts.
- Non-power-of-two N: `ptr` wraps at N, never at 2^SW.

## Timing
- Reset values, applied on the first rising edge with `rst` high:
  - `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `ptr` = 0.
  - `in_ready` = `gnt` during reset, because `load` = 1. Accepted data is discarded and no state changes while `rst` is high.
- Latency: one cycle. A beat accepted at edge k appears on `out_data` with `out_valid` = 1 after edge k.
- Throughput: one beat per cycle while `out_ready` stays high.
- Simultaneous drain and fill (`out_valid && out_ready && |gnt`): the new beat replaces the old one in the same edge, and `out_valid` stays 1.
- Reset asserted mid-transfer: the held beat is lost, `out_valid` = 0 after the edge, and `ptr` returns to 0.
- `sel` changes take effect combinationally. The beat already in the register is unaffected.

## Test plan
- Reset and idle: hold `rst` 2 cycles with `in_valid` = 4'b1111 → `out_valid` = 0, `out_data` = 0, `out_idx` = 0. After release, the first beat is from channel 0.
- MODE 0 external select: set `sel` = 2, `in_valid` = 4'b1111, `in_data[2]` = 32'hDEADBEEF → next cycle `out_data` = DEADBEEF, `out_idx` = 2, `in_ready` = 4'b0100. Setting `sel` = 2 with `in_valid[2]` = 0 → `out_valid` drops to 0.
- MODE 1 priority: `in_valid` = 4'b1010 → channel 1 is served every cycle and channel 3 is starved. Dropping channel 1 → channel 3 is served next cycle.
- MODE 2 round-robin, N = 4, all valid, `out_ready` = 1 for 8 cycles → `out_idx` sequence 0,1,2,3,0,1,2,3. Repeat with N = 3 → sequence 0,1,2,0,1,2.
- Backpressure: hold `out_ready` = 0 for 3 cycles with a beat held → `out_data`, `out_idx` and `ptr` are stable, `in_ready` = 0. Release → throughput resumes with no beat lost or duplicated, confirmed by a scoreboard with per-channel counters.
- Mid-operation reset: assert `rst` while `out_valid` = 1 and `ptr` = 2 → after the edge `out_valid` = 0. The first grant after release goes to channel 0.
